// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Baud ticks per bit period.
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running 16x baud tick generator: one-cycle tick every dvsr+1 clocks.
// A synchronous clear restarts the count so a frame begins on a full period.
module baud_tick_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] r_cnt;

  assign tick = (r_cnt == dvsr);

  // Count 0..dvsr and wrap on the tick; clr forces the count back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a show-ahead FIFO: pops a word in IDLE, then sends
// start bit, DBIT data bits LSB first and SB_TICK ticks of stop level.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              fifo_empty,
  input  logic [DBIT-1:0]   fifo_rd_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              tx_busy
);

  // Tick counter must be wide enough to reach SB_TICK-1 for long stop bits.
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  uart_state_t       r_state;
  uart_state_t       w_state_next;
  logic [S_W-1:0]    r_s;
  logic [S_W-1:0]    w_s_next;
  logic [N_W-1:0]    r_n;
  logic [N_W-1:0]    w_n_next;
  logic [DBIT-1:0]   r_b;
  logic [DBIT-1:0]   w_b_next;
  logic [DVSR_W-1:0] r_dvsr_q;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_tick;
  logic              w_pop;

  // Pop only from IDLE with data available; held off while reset is asserted.
  assign w_pop = ~reset & (r_state == IDLE) & ~fifo_empty;
  assign tx    = r_tx;

  baud_tick_gen #(
    .DVSR_W(DVSR_W)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (w_pop),
    .dvsr  (r_dvsr_q),
    .tick  (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: tick/bit counters, shift register, divisor copy, tx line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s      <= '0;
      r_n      <= '0;
      r_b      <= '0;
      r_dvsr_q <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_s  <= w_s_next;
      r_n  <= w_n_next;
      r_b  <= w_b_next;
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_dvsr_q <= dvsr;
      end
    end
  end

  // Next-state and counter/shift update logic.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_b_next     = fifo_rd_data;
          w_s_next     = '0;
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = DATA;
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end else begin
          w_s_next = r_s;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + N_W'(1);
            end
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end else begin
          w_s_next = r_s;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_next = IDLE;
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end else begin
          w_s_next = r_s;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output decode: pop strobe, busy flag and next serial line level.
  always_comb begin
    fifo_rd = w_pop;
    tx_busy = (r_state != IDLE);
    case (r_state)
      IDLE:    w_tx_next = 1'b1;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_b[0];
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-parameter instance fed by a small FIFO
// model, plus a DBIT=7 / SB_TICK=32 instance driven directly.
module tb_uart_tx;

  logic        clk;
  logic        reset;
  logic [10:0] dvsr;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd;
  logic        tx;
  logic        tx_busy;

  logic [10:0] dvsr7;
  logic        empty7;
  logic [6:0]  data7;
  logic        fifo_rd7;
  logic        tx7;
  logic        busy7;

  logic [7:0]  mem [0:15];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;

  int n_vec;
  int n_err;

  uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  uart_tx #(.DBIT(7), .SB_TICK(32), .DVSR_W(11)) dut7 (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr7),
    .fifo_empty   (empty7),
    .fifo_rd_data (data7),
    .fifo_rd      (fifo_rd7),
    .tx           (tx7),
    .tx_busy      (busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead FIFO model; the read pointer survives DUT reset on purpose.
  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  initial rd_ptr = 4'd0;
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Expected tx at the k-th falling edge after the pop edge.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int nbits, input int per);
    int p;
    if (k < 2) return 1'b1;
    p = (k - 2) / per;
    if (p == 0) return 1'b0;
    if (p <= nbits) return d[p-1];
    return 1'b1;
  endfunction

  // Follow one 8N1 frame from the falling edge after the pop to the IDLE cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input int dv);
    int len;
    int bad;
    int busy_cnt;
    int pops;
    len      = 160 * (dv + 1);
    bad      = 0;
    busy_cnt = 0;
    pops     = 0;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      #1;
      if (tx !== exp_tx(k, d, 8, 16 * (dv + 1))) bad++;
      if (k <= len && tx_busy === 1'b1) busy_cnt++;
      if (k <= len && fifo_rd === 1'b1) pops++;
    end
    chk({tag, "_txwave_bad"}, bad, 0);
    chk({tag, "_busy_clks"}, busy_cnt, len);
    chk({tag, "_pops_in_frame"}, pops, 0);
    chk({tag, "_busy_end"}, {31'd0, tx_busy}, 0);
  endtask

  initial begin
    int pops;
    int lows;
    int bad;
    int busy_cnt;
    int stop_hi;
    n_vec  = 0;
    n_err  = 0;
    wr_ptr = 4'd0;
    reset  = 1'b1;
    dvsr   = 11'd0;
    dvsr7  = 11'd0;
    empty7 = 1'b1;
    data7  = 7'd0;

    // Reset state with the FIFO empty
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_fifo_rd", {31'd0, fifo_rd}, 0);
    chk("rst_busy", {31'd0, tx_busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    pops = 0;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (fifo_rd === 1'b1) pops++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("idle_pops", pops, 0);
    chk("idle_tx_or_busy", lows, 0);

    // Single 0xA5 at dvsr=0
    @(negedge clk);
    push(8'hA5);
    #1;
    chk("a5_rd", {31'd0, fifo_rd}, 1);
    run_frame("a5", 8'hA5, 0);
    chk("a5_one_pop", {28'd0, rd_ptr}, 1);

    // Back-to-back 0x00, 0xFF at dvsr=2
    dvsr = 11'd2;
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    #1;
    chk("b2b_rd0", {31'd0, fifo_rd}, 1);
    run_frame("b2b0", 8'h00, 2);
    chk("b2b_rd1", {31'd0, fifo_rd}, 1);
    run_frame("b2b1", 8'hFF, 2);
    chk("b2b_ptr", {28'd0, rd_ptr}, 3);

    // Divisor changes 2->5 mid-frame; takes effect on the next frame only
    @(negedge clk);
    push(8'h5A);
    push(8'hC3);
    #1;
    chk("dv_rd0", {31'd0, fifo_rd}, 1);
    fork
      run_frame("dv0", 8'h5A, 2);
      begin
        repeat (200) @(negedge clk);
        dvsr = 11'd5;
      end
    join
    chk("dv_rd1", {31'd0, fifo_rd}, 1);
    run_frame("dv1", 8'hC3, 5);

    // Reset during data bit 3, second word waiting
    dvsr = 11'd0;
    @(negedge clk);
    push(8'h3C);
    push(8'h96);
    #1;
    chk("rs_rd0", {31'd0, fifo_rd}, 1);
    repeat (70) @(negedge clk);
    #1;
    chk("rs_busy_before", {31'd0, tx_busy}, 1);
    reset = 1'b1;
    #1;
    chk("rs_tx", {31'd0, tx}, 1);
    chk("rs_busy", {31'd0, tx_busy}, 0);
    chk("rs_fifo_rd", {31'd0, fifo_rd}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rs_rd1", {31'd0, fifo_rd}, 1);
    run_frame("rs1", 8'h96, 0);

    // DBIT=7, SB_TICK=32 instance at dvsr=0
    @(negedge clk);
    data7  = 7'h55;
    empty7 = 1'b0;
    #1;
    chk("d7_rd", {31'd0, fifo_rd7}, 1);
    bad      = 0;
    busy_cnt = 0;
    stop_hi  = 0;
    pops     = 0;
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      empty7 = 1'b1;
      #1;
      if (tx7 !== exp_tx(k, {1'b0, 7'h55}, 7, 16)) bad++;
      if (k <= 160 && busy7 === 1'b1) busy_cnt++;
      if (k >= 130 && tx7 === 1'b1) stop_hi++;
      if (fifo_rd7 === 1'b1) pops++;
    end
    chk("d7_txwave_bad", bad, 0);
    chk("d7_busy_clks", busy_cnt, 160);
    chk("d7_stop_high_clks", stop_hi, 32);
    chk("d7_pops_in_frame", pops, 0);
    chk("d7_busy_end", {31'd0, busy7}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
